// File: rtl/segre_pkg.sv
// Shared core definitions: word size, dcache geometry, fill FSM states.
// Geometry constants are common to the tag array and the fill responder.
package segre_pkg;

    localparam int WORD_SIZE = 32;

    localparam int DCACHE_BYTES_PER_LANE = 16;
    localparam int DCACHE_ELEMS_PER_LANE =
        DCACHE_BYTES_PER_LANE / (WORD_SIZE / 8);
    localparam int DCACHE_ADDR_BYTE_SIZE =
        $clog2(DCACHE_BYTES_PER_LANE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } dcache_fill_state_t;

    function automatic logic [WORD_SIZE-1:0] line_align(
        input logic [WORD_SIZE-1:0] addr,
        input int unsigned          byte_bits
    );
        logic [WORD_SIZE-1:0] mask;
        mask = '1;
        mask = mask << byte_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/segre_mmu_line_buffer.sv
// Beat counter and word-indexed line register for dcache fills.
// line_o already includes the beat arriving this cycle.
module segre_mmu_line_buffer #(
    parameter  int WORD_W = 32,
    parameter  int ELEMS  = 4,
    localparam int LINE_W = WORD_W * ELEMS,
    localparam int CNT_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              last_o,
    output logic [LINE_W-1:0] line_o
);

    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    assign last_o = valid_i && (cnt_q == CNT_W'(ELEMS - 1));

    always_comb begin
        line_d = line_q;
        if (valid_i) begin
            line_d[cnt_q*WORD_W +: WORD_W] = data_i;
        end
    end

    assign line_o = line_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (valid_i) begin
            cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/segre_mmu_dcache_fill.sv
// Dcache miss responder: line-aligned memory read, beat assembly, fill pulse.
// Optional watchdog: define SEGRE_MMU_FILL_TIMEOUT_EN (adds fill_err_o).
module segre_mmu_dcache_fill
    import segre_pkg::*;
#(
    parameter  int NUM_LANES      = 4,
    parameter  int BYTES_PER_LANE = DCACHE_BYTES_PER_LANE,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = $clog2(NUM_LANES),
    localparam int ELEMS          = BYTES_PER_LANE / (WORD_SIZE / 8),
    localparam int LINE_W         = WORD_SIZE * ELEMS,
    localparam int BYTE_BITS      = $clog2(BYTES_PER_LANE)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dc_miss_i,
    input  logic [WORD_SIZE-1:0] dc_addr_i,
    input  logic [IDX_W-1:0]     dc_lru_index_i,
    output logic                 mem_rd_req_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    input  logic                 mem_ready_i,
    input  logic                 mem_rd_valid_i,
    input  logic [WORD_SIZE-1:0] mem_rd_data_i,
    output logic                 mmu_data_o,
    output logic [WORD_SIZE-1:0] mmu_addr_o,
    output logic [IDX_W-1:0]     mmu_lru_index_o,
    output logic [LINE_W-1:0]    mmu_line_o,
`ifdef SEGRE_MMU_FILL_TIMEOUT_EN
    output logic                 fill_err_o,
`endif
    output logic                 busy_o
);

    dcache_fill_state_t state_q;

    logic [WORD_SIZE-1:0] addr_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 beat;
    logic                 clr;
    logic                 last;
    logic [LINE_W-1:0]    line;
    logic                 tmo_hit;

    // Beats only count in WAIT, so a valid alongside ready is dropped.
    assign beat   = (state_q == WAIT) && mem_rd_valid_i;
    assign clr    = (state_q == REQ) && mem_ready_i;
    assign busy_o = (state_q != IDLE);

    assign mem_addr_o = addr_q;

    segre_mmu_line_buffer #(
        .WORD_W (WORD_SIZE),
        .ELEMS  (ELEMS)
    ) u_line_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clr),
        .valid_i (beat),
        .data_i  (mem_rd_data_i),
        .last_o  (last),
        .line_o  (line)
    );

`ifdef SEGRE_MMU_FILL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_q;
    logic             waiting;

    assign waiting = (state_q == REQ) || (state_q == WAIT);
    assign tmo_hit = waiting && !clr && !beat &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Progress of any kind restarts the watchdog window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (!waiting || clr || beat || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_err_o <= 1'b0;
        end else begin
            fill_err_o <= tmo_hit;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            idx_q           <= '0;
            mem_rd_req_o    <= 1'b0;
            mmu_data_o      <= 1'b0;
            mmu_addr_o      <= '0;
            mmu_lru_index_o <= '0;
            mmu_line_o      <= '0;
        end else begin
            mmu_data_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dc_miss_i) begin
                        addr_q       <= line_align(dc_addr_i, BYTE_BITS);
                        idx_q        <= dc_lru_index_i;
                        mem_rd_req_o <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        mem_rd_req_o <= 1'b0;
                        state_q      <= WAIT;
                    end else if (tmo_hit) begin
                        mem_rd_req_o <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                WAIT: begin
                    if (last) begin
                        mmu_data_o      <= 1'b1;
                        mmu_addr_o      <= addr_q;
                        mmu_lru_index_o <= idx_q;
                        mmu_line_o      <= line;
                        state_q         <= FILL;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                    end
                end
                FILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segre_mmu_dcache_fill.sv
// Randomized bench for segre_mmu_dcache_fill against a cycle-level
// transaction model (latency formula, expected line from beat list).
module tb_segre_mmu_dcache_fill;

    localparam int W = 32;
    localparam int E = 4;
    localparam int LW = W * E;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          dc_miss_i;
    logic [W-1:0]  dc_addr_i;
    logic [1:0]    dc_lru_index_i;
    logic          mem_rd_req_o;
    logic [W-1:0]  mem_addr_o;
    logic          mem_ready_i;
    logic          mem_rd_valid_i;
    logic [W-1:0]  mem_rd_data_i;
    logic          mmu_data_o;
    logic [W-1:0]  mmu_addr_o;
    logic [1:0]    mmu_lru_index_o;
    logic [LW-1:0] mmu_line_o;
    logic          busy_o;
`ifdef SEGRE_MMU_FILL_TIMEOUT_EN
    logic          fill_err_o;
`endif

    int errors = 0;
    int checks = 0;
    int fill_cnt = 0;
    int exp_fills = 0;

    segre_mmu_dcache_fill #(
        .NUM_LANES      (4),
        .BYTES_PER_LANE (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dc_miss_i       (dc_miss_i),
        .dc_addr_i       (dc_addr_i),
        .dc_lru_index_i  (dc_lru_index_i),
        .mem_rd_req_o    (mem_rd_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rd_valid_i  (mem_rd_valid_i),
        .mem_rd_data_i   (mem_rd_data_i),
        .mmu_data_o      (mmu_data_o),
        .mmu_addr_o      (mmu_addr_o),
        .mmu_lru_index_o (mmu_lru_index_o),
        .mmu_line_o      (mmu_line_o),
`ifdef SEGRE_MMU_FILL_TIMEOUT_EN
        .fill_err_o      (fill_err_o),
`endif
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (mmu_data_o) fill_cnt++;
    end

    task automatic check(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 128'(busy_o), 128'(0));
        check({tag, "_req"}, 128'(mem_rd_req_o), 128'(0));
        check({tag, "_fill"}, 128'(mmu_data_o), 128'(0));
    endtask

    // One miss transaction. The expected schedule comes from the latency
    // rule: REQ at cycle 1, ready after rdly, beats every gap+1 cycles.
    task automatic run_miss(
        input logic [W-1:0] addr,
        input logic [1:0]   lru,
        input int           rdly,
        input int           gap,
        input bit           fixed,
        input int           abort_after,
        input bit           hold,
        input logic [W-1:0] next_addr
    );
        logic [W-1:0]  w [E];
        logic [LW-1:0] exp_line;
        logic [W-1:0]  exp_addr;
        int b0, last_t, nb;
        bit done, bt;

        exp_addr = addr & ~32'hF;
        for (int i = 0; i < E; i++) begin
            w[i] = fixed ? (32'hA0 + i) : $urandom;
            exp_line[i*W +: W] = w[i];
        end
        b0 = 2 + rdly;
        last_t = b0 + (E - 1) * (gap + 1);

        @(posedge clk_i); #1;
        dc_miss_i = 1'b1;
        dc_addr_i = addr;
        dc_lru_index_i = lru;
        mem_ready_i = 1'b0;
        mem_rd_valid_i = 1'b0;
        @(negedge clk_i);
        check("c0_req", 128'(mem_rd_req_o), 128'(0));
        check("c0_fill", 128'(mmu_data_o), 128'(0));

        nb = 0;
        done = 1'b0;
        for (int t = 1; t <= last_t + 1 && !done; t++) begin
            @(posedge clk_i); #1;
            bt = (t >= b0) && ((t - b0) % (gap + 1) == 0) && (nb < E);
            mem_ready_i = (t == 1 + rdly);
            mem_rd_valid_i = bt || (t == 1 + rdly);
            mem_rd_data_i = bt ? w[nb] : $urandom;
            if (t >= 2) begin
                dc_addr_i = $urandom;
                dc_lru_index_i = (lru == 2'd0) ? 2'd3 : 2'd0;
                dc_miss_i = 1'($urandom_range(0, 1));
            end
            if (t == last_t + 1) begin
                dc_miss_i = hold;
                dc_addr_i = next_addr;
                dc_lru_index_i = lru;
            end
            @(negedge clk_i);
            check("busy", 128'(busy_o), 128'(1));
            if (t <= 1 + rdly) begin
                check("req_hold", 128'(mem_rd_req_o), 128'(1));
                check("req_addr", 128'(mem_addr_o), 128'(exp_addr));
            end else begin
                check("req_drop", 128'(mem_rd_req_o), 128'(0));
            end
            check("fill_pulse", 128'(mmu_data_o), 128'(t == last_t + 1));
            if (t == last_t + 1) begin
                check("fill_addr", 128'(mmu_addr_o), 128'(exp_addr));
                check("fill_lru", 128'(mmu_lru_index_o), 128'(lru));
                check("fill_line", 128'(mmu_line_o), 128'(exp_line));
                exp_fills++;
            end
            if (bt) nb++;
            if (abort_after > 0 && nb == abort_after) done = 1'b1;
        end

        if (done) begin
            @(posedge clk_i); #1;
            rst_i = 1'b1;
            dc_miss_i = 1'b0;
            mem_ready_i = 1'b0;
            mem_rd_valid_i = 1'b0;
            @(negedge clk_i);
            check_quiet("rst");
            check("rst_mline", 128'(mmu_line_o), 128'(0));
            check("rst_maddr", 128'(mem_addr_o), 128'(0));
            for (int k = 0; k < 2; k++) begin
                @(posedge clk_i); #1;
                rst_i = 1'b0;
                mem_rd_valid_i = 1'b1;
                mem_rd_data_i = $urandom;
                @(negedge clk_i);
                check_quiet("post_rst");
                check("post_rst_line", 128'(mmu_line_o), 128'(0));
            end
            @(posedge clk_i); #1;
            mem_rd_valid_i = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        dc_miss_i = 1'b0;
        dc_addr_i = '0;
        dc_lru_index_i = '0;
        mem_ready_i = 1'b0;
        mem_rd_valid_i = 1'b1;
        mem_rd_data_i = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_quiet("reset");
        check("reset_maddr", 128'(mem_addr_o), 128'(0));
        check("reset_faddr", 128'(mmu_addr_o), 128'(0));
        check("reset_lru", 128'(mmu_lru_index_o), 128'(0));
        check("reset_line", 128'(mmu_line_o), 128'(0));

        // Stray beats while idle must be dropped.
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            check_quiet("stray");
            @(posedge clk_i); #1;
        end
        mem_rd_valid_i = 1'b0;

        run_miss(32'h0000_1234, 2'd2, 0, 0, 1'b1, 0, 1'b0, '0);
        run_miss(32'h0000_5678, 2'd1, 5, 0, 1'b0, 0, 1'b0, '0);
        run_miss(32'h0000_9ABC, 2'd2, 0, 2, 1'b0, 0, 1'b0, '0);
        run_miss(32'h0000_4444, 2'd3, 1, 0, 1'b0, 2, 1'b0, '0);
        run_miss(32'h0000_1234, 2'd2, 0, 0, 1'b1, 0, 1'b0, '0);
        run_miss(32'h0000_0100, 2'd1, 0, 0, 1'b0, 0, 1'b1, 32'h0000_0200);
        run_miss(32'h0000_0200, 2'd1, 0, 0, 1'b0, 0, 1'b0, '0);

        for (int n = 0; n < 12; n++) begin
            run_miss($urandom, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 5), $urandom_range(0, 3),
                     1'b0, 0, 1'b0, '0);
        end

`ifdef SEGRE_MMU_FILL_TIMEOUT_EN
        begin
            int errs_seen;
            int fills0;
            errs_seen = 0;
            fills0 = fill_cnt;
            @(posedge clk_i); #1;
            dc_miss_i = 1'b1;
            dc_addr_i = 32'h0000_0300;
            mem_ready_i = 1'b0;
            mem_rd_valid_i = 1'b0;
            for (int t = 1; t <= 40; t++) begin
                @(posedge clk_i); #1;
                dc_miss_i = 1'b0;
                @(negedge clk_i);
                if (fill_err_o) begin
                    errs_seen++;
                    check("tmo_busy", 128'(busy_o), 128'(0));
                end
            end
            check("tmo_err_cnt", 128'(errs_seen), 128'(1));
            check("tmo_no_fill", 128'(fill_cnt), 128'(fills0));
        end
`endif

        dc_miss_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("fill_total", 128'(fill_cnt), 128'(exp_fills));
        check_quiet("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segre_mmu_dcache_fill.md
Name: segre_mmu_dcache_fill

Overview:
Memory-side responder for data-cache misses. It accepts a miss (address plus victim lane index) from the dcache tag/data arrays and issues a line-aligned read to memory. It assembles the returned words into one cache line and presents it back as a single-cycle fill pulse. The dcache tag array consumes that pulse as its fill strobe, together with the lane index.

Parameters:
NUM_LANES, 4, number of dcache lanes; sets the index width ($clog2(NUM_LANES)).
BYTES_PER_LANE, 16, line size in bytes; ELEMS_PER_LANE = BYTES_PER_LANE/(WORD_SIZE/8) memory beats per line.
TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
clk_i  in  1  single clock
rst_i  in  1  reset, asynchronous, active-high
dc_miss_i  in  1  dcache miss request, held high until fill
dc_addr_i  in  WORD_SIZE  miss address (byte address)
dc_lru_index_i  in  $clog2(NUM_LANES)  victim lane for the fill
mem_rd_req_o  out  1  memory read request
mem_addr_o  out  WORD_SIZE  line-aligned read address
mem_ready_i  in  1  memory accepts request
mem_rd_valid_i  in  1  one returned data beat valid
mem_rd_data_i  in  WORD_SIZE  returned beat data
mmu_data_o  out  1  fill strobe, one cycle
mmu_addr_o  out  WORD_SIZE  line-aligned fill address
mmu_lru_index_o  out  $clog2(NUM_LANES)  lane to write
mmu_line_o  out  WORD_SIZE*ELEMS_PER_LANE  assembled line
busy_o  out  1  state != IDLE

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0; the line buffer, beat counter and latched address/index are cleared.
  - Reset asserted mid-transaction aborts it. No fill pulse is emitted afterwards.
- FSM states: IDLE, REQ, WAIT, FILL.
- IDLE:
  - dc_miss_i=1 latches dc_addr_i with bits [ADDR_BYTE_SIZE-1:0] forced to 0, and latches dc_lru_index_i.
  - Next state is REQ.
  - mem_rd_valid_i is ignored in IDLE (stray beats after reset are dropped).
- REQ:
  - mem_rd_req_o=1 and mem_addr_o=latched aligned address, both registered.
  - Both are held until mem_ready_i=1.
  - On mem_ready_i=1: next state is WAIT, beat counter reset to 0.
- WAIT:
  - Each mem_rd_valid_i=1 writes mem_rd_data_i into line bits [cnt*WORD_SIZE +: WORD_SIZE], then cnt increments.
  - The beat with cnt==ELEMS_PER_LANE-1 moves the FSM to FILL.
  - Beats are counted only in WAIT. A valid in the same cycle as mem_ready_i is not sampled.
  - Gaps between beats are allowed.
- FILL:
  - mmu_data_o=1 for exactly one cycle.
  - mmu_addr_o, mmu_lru_index_o and mmu_line_o are valid in that cycle and are held stable until the next fill.
  - Next state is IDLE.
- A new miss is accepted no earlier than the IDLE cycle after FILL.
- dc_miss_i changes while busy (address change, deassert) are ignored. The latched request completes.
- Minimum latency, with ready at first REQ cycle and back-to-back beats (4 beats at defaults): miss sampled at cycle 0, REQ cycle 1, WAIT cycles 2-5, fill pulse cycle 6.
- mmu_lru_index_o is the index latched at miss time, not the live input.

Optional Feature:
- Macro: SEGRE_MMU_FILL_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in REQ and WAIT and is cleared on every state change and on every accepted beat.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses an extra output, fill_err_o (1 bit), for one cycle.
  - No mmu_data_o pulse occurs.
  - The counter and fill_err_o reset to 0.
- When undefined: no counter and no fill_err_o port; REQ and WAIT wait indefinitely.

Decomposition:
- segre_pkg receives the dcache_fill_state_t enum (IDLE, REQ, WAIT, FILL).
- segre_pkg also receives the shared dcache geometry constants: DCACHE_BYTES_PER_LANE, DCACHE_ELEMS_PER_LANE, DCACHE_ADDR_BYTE_SIZE. These must also be used by the tag array.
- WORD_SIZE comes from segre_pkg.
- One sub-module: segre_mmu_line_buffer.
  - Contains the beat counter and word-indexed line register.
  - Inputs: clear, beat valid, beat data.
  - Outputs: last-beat flag and the line.

Test Plan:
- Basic miss at addr 0x0000_1234, lru 2; ready in first REQ cycle; beats 0xA0,0xA1,0xA2,0xA3 back-to-back:
  - mem_addr_o=0x0000_1230 at cycle 1.
  - mmu_data_o high only at cycle 6.
  - mmu_line_o = {0xA3,0xA2,0xA1,0xA0} (word 0 at LSBs), mmu_lru_index_o=2.
- mem_ready_i held low 5 cycles in REQ: mem_rd_req_o and mem_addr_o remain stable for all 5 cycles. Fill occurs 5 cycles later than the basic case.
- Beats with 2-cycle gaps, and dc_lru_index_i changed to 0 during WAIT: line is assembled correctly and mmu_lru_index_o stays at the latched value 2.
- rst_i pulsed after beat 2, then mem_rd_valid_i asserted 2 more times: state IDLE, all outputs 0, no mmu_data_o pulse. A following miss completes normally.
- Two consecutive misses (0x100, then 0x200 held high): second mem_rd_req_o is asserted no earlier than 2 cycles after the first fill pulse. Each line is returned exactly once.
- With SEGRE_MMU_FILL_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never returns data: fill_err_o pulses once, busy_o drops, mmu_data_o is never asserted.
